// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Brief    : Shared AES state types, occupancy encoding and byte-index helper.
// Revision : 1.0
// ============================================================================
package aes_pkg;

    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_t;

    localparam int AES_NB = 4;

    // Column-major AES state layout: byte k holds row k%4, column k/4.
    function automatic int byte_idx(input int row, input int col);
        return 4 * col + row;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inv_shift_rows_comb.sv
`default_nettype none
// ============================================================================
// Module   : inv_shift_rows_comb
// Brief    : Combinational AES row rotation; dir=0 inverse, dir=1 forward.
// Revision : 1.0
// ============================================================================
module inv_shift_rows_comb
    import aes_pkg::*;
(
    input  logic       dir,
    input  aes_state_t data_in,
    output aes_state_t data_out
);

    aes_state_t w_inv;
    aes_state_t w_fwd;

    for (genvar c = 0; c < AES_NB; c++) begin : g_col
        for (genvar r = 0; r < AES_NB; r++) begin : g_row
            localparam int C_DST     = byte_idx(r, c);
            localparam int C_SRC_INV = byte_idx(r, (c - r + AES_NB) % AES_NB);
            localparam int C_SRC_FWD = byte_idx(r, (c + r) % AES_NB);

            assign w_inv[8*C_DST +: 8] = data_in[8*C_SRC_INV +: 8];
            assign w_fwd[8*C_DST +: 8] = data_in[8*C_SRC_FWD +: 8];
        end
    end

    assign data_out = dir ? w_fwd : w_inv;

endmodule
`default_nettype wire

// File: rtl/inv_shift_rows_stage.sv
`default_nettype none
// ============================================================================
// Module   : inv_shift_rows_stage
// Brief    : Registered valid/ready AES InvShiftRows stage with a skid register.
//            Define SHIFTROWS_DIR_SEL_EN to add a per-beat in_dir (1 = forward).
// Revision : 1.0
// ============================================================================
module inv_shift_rows_stage
    import aes_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
`ifdef SHIFTROWS_DIR_SEL_EN
    input  logic             in_dir,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic [CNT_W-1:0] blk_cnt
);

    occ_state_t       state_q, state_d;
    aes_state_t       out_q,   out_d;
    aes_state_t       skid_q,  skid_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             in_ready_q;

    logic             w_dir;
    aes_state_t       w_xf;
    logic             w_accept;
    logic             w_drain;

`ifdef SHIFTROWS_DIR_SEL_EN
    assign w_dir = in_dir;
`else
    assign w_dir = 1'b0;
`endif

    // Transform at capture so both holding registers carry finished data.
    inv_shift_rows_comb u_perm (
        .dir      (w_dir),
        .data_in  (in_data),
        .data_out (w_xf)
    );

    assign w_accept = in_valid & in_ready_q;
    assign w_drain  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;

        if (w_drain) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end

        unique case (state_q)
            EMPTY: begin
                if (w_accept) begin
                    state_d = ONE;
                    out_d   = w_xf;
                end
            end
            ONE: begin
                if (w_accept && w_drain) begin
                    out_d = w_xf;
                end else if (w_accept) begin
                    state_d = TWO;
                    skid_d  = w_xf;
                end else if (w_drain) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (w_drain) begin
                    state_d = ONE;
                    out_d   = skid_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= EMPTY;
            out_q      <= '0;
            skid_q     <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
            cnt_q      <= cnt_d;
            in_ready_q <= (state_d != TWO);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = out_q;
    assign blk_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_inv_shift_rows_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_inv_shift_rows_stage
// Brief    : Self-checking bench for inv_shift_rows_stage (queue reference model).
// Revision : 1.0
// ============================================================================
module tb_inv_shift_rows_stage;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             n_rst;
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_data;
`ifdef SHIFTROWS_DIR_SEL_EN
    logic             in_dir;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_data;
    logic [CNT_W-1:0] blk_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [127:0]     mq[$];
    logic [CNT_W-1:0] m_cnt;
    logic             m_rdy;

    typedef struct {
        logic [127:0] din;
        logic         dir;
        logic [127:0] dout;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    inv_shift_rows_stage #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef SHIFTROWS_DIR_SEL_EN
        .in_dir    (in_dir),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .blk_cnt   (blk_cnt)
    );

    // Matrix view of the state: row r of the result is row r of the input rotated.
    function automatic logic [127:0] ref_xf(input logic [127:0] d, input logic fwd);
        logic [7:0]   m[4][4];
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = d[8*(4*c+r) +: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[8*(4*c+r) +: 8] = fwd ? m[r][(c + r) % 4] : m[r][(c + 4 - r) % 4];
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, 128'(out_valid), 128'(mq.size() != 0));
        chk({tag, ".in_ready"},  128'(in_ready),  128'(m_rdy));
        chk({tag, ".blk_cnt"},   128'(blk_cnt),   128'(m_cnt));
        if (mq.size() != 0)
            chk({tag, ".out_data"}, out_data, mq[0]);
    endtask

    task automatic model_reset();
        mq.delete();
        m_cnt = '0;
        m_rdy = 1'b0;
    endtask

    // Drive one cycle from a negedge, advance the model, return at the next negedge.
    task automatic step(input logic v, input logic [127:0] d, input logic dir, input logic ordy);
        logic         acc;
        logic         drn;
        logic [127:0] tmp;
        in_valid  = v;
        in_data   = d;
`ifdef SHIFTROWS_DIR_SEL_EN
        in_dir    = dir;
`endif
        out_ready = ordy;
        acc = v && m_rdy;
        drn = (mq.size() != 0) && ordy;
        if (drn) begin
            tmp = mq.pop_front();
            m_cnt = m_cnt + 1'b1;
        end
        if (acc) mq.push_back(ref_xf(d, dir));
        m_rdy = (mq.size() < 2);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        n_rst = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic rnd_dir();
`ifdef SHIFTROWS_DIR_SEL_EN
        return 1'($urandom & 1);
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        logic [127:0] a, b, c, held;

        tbl.push_back('{128'h73744765635354655d5b56727b746f5d, 1'b0, 128'h7b5b54657374566563746f725d53475d});
        tbl.push_back('{128'h0f0e0d0c0b0a09080706050403020100, 1'b0, 128'h0306090c0f0205080b0e0104070a0d00});
        tbl.push_back('{{128{1'b1}},                            1'b0, {128{1'b1}}});
        tbl.push_back('{128'h000000ff000000ff000000ff000000ff, 1'b0, 128'h000000ff000000ff000000ff000000ff});
`ifdef SHIFTROWS_DIR_SEL_EN
        tbl.push_back('{128'h7b5b54657374566563746f725d53475d, 1'b1, 128'h73744765635354655d5b56727b746f5d});
        tbl.push_back('{128'h0f0e0d0c0b0a09080706050403020100, 1'b1, 128'h0b06010c07020d08030e09040f0a0500});
`endif

        n_rst     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
`ifdef SHIFTROWS_DIR_SEL_EN
        in_dir    = 1'b0;
`endif
        out_ready = 1'b0;
        model_reset();
        #1;
        chk("reset.out_valid", 128'(out_valid), 128'(0));
        chk("reset.in_ready",  128'(in_ready),  128'(0));
        chk("reset.blk_cnt",   128'(blk_cnt),   128'(0));
        chk("reset.out_data",  out_data,        128'(0));
        @(negedge clk);
        n_rst = 1'b1;
        check_all("release");
        step(1'b0, '0, 1'b0, 1'b0);
        check_all("ready_up");

        for (int i = 0; i < tbl.size(); i++) begin
            step(1'b1, tbl[i].din, tbl[i].dir, 1'b1);
            chk($sformatf("vec%0d.data", i), out_data, tbl[i].dout);
            check_all($sformatf("vec%0d", i));
            step(1'b0, '0, 1'b0, 1'b1);
            chk($sformatf("vec%0d.cnt", i), 128'(blk_cnt), 128'((i + 1) % (1 << CNT_W)));
        end

        // Back-pressure: A and B fill the stage, C waits, order preserved on release.
        do_reset();
        a = rnd128(); b = rnd128(); c = rnd128();
        step(1'b1, a, 1'b0, 1'b0);
        check_all("bp.a");
        step(1'b1, b, 1'b0, 1'b0);
        chk("bp.two_ready", 128'(in_ready), 128'(0));
        check_all("bp.b");
        held = ref_xf(a, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, c, 1'b0, 1'b0);
            chk("bp.stall_data", out_data, held);
            check_all("bp.stall");
        end
        step(1'b1, c, 1'b0, 1'b1);
        chk("bp.order_b", out_data, ref_xf(b, 1'b0));
        check_all("bp.rel1");
        step(1'b1, c, 1'b0, 1'b1);
        chk("bp.order_c", out_data, ref_xf(c, 1'b0));
        check_all("bp.rel2");
        step(1'b0, '0, 1'b0, 1'b1);
        chk("bp.empty", 128'(out_valid), 128'(0));

        // Streaming: full throughput with out_ready held high.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, rnd128(), 1'b0, 1'b1);
            chk("stream.valid", 128'(out_valid), 128'(1));
            chk("stream.ready", 128'(in_ready), 128'(1));
            check_all("stream");
        end
        step(1'b0, '0, 1'b0, 1'b1);
        chk("stream.cnt", 128'(blk_cnt), 128'(8));

        // Counter wrap at CNT_W = 4.
        do_reset();
        for (int i = 0; i < 17; i++) step(1'b1, rnd128(), 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("wrap.cnt", 128'(blk_cnt), 128'(1));

        // Reset while holding two states.
        step(1'b1, rnd128(), 1'b0, 1'b0);
        step(1'b1, rnd128(), 1'b0, 1'b0);
        chk("mid.two", 128'(in_ready), 128'(0));
        #2;
        n_rst = 1'b0;
        #1;
        model_reset();
        chk("mid.out_valid", 128'(out_valid), 128'(0));
        chk("mid.in_ready",  128'(in_ready),  128'(0));
        chk("mid.blk_cnt",   128'(blk_cnt),   128'(0));
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0, 1'b1);
            chk("mid.no_old", 128'(out_valid), 128'(0));
            check_all("mid.after");
        end

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            step(1'(($urandom % 4) != 0), rnd128(), rnd_dir(), 1'(($urandom % 3) != 0));
            check_all("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
